// File: rtl/axi4lite_slave_regfile.sv
// AXI4-Lite responder over a small bank of byte-strobed read/write registers.
// Latency: write commits and read data are registered, both appear one edge after the handshake.
// Backpressure: one AW and one W buffered, B stall holds them; reads are single outstanding.
module axi4lite_slave_regfile #(
    parameter int ADDR_WIDTH = 2,
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REGS   = 3
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [ADDR_WIDTH-1:0]          s_awaddr,
    input  logic                           s_awvalid,
    output logic                           s_awready,
    input  logic [DATA_WIDTH-1:0]          s_wdata,
    input  logic [DATA_WIDTH/8-1:0]        s_wstrb,
    input  logic                           s_wvalid,
    output logic                           s_wready,
    output logic [1:0]                     s_bresp,
    output logic                           s_bvalid,
    input  logic                           s_bready,
    input  logic [ADDR_WIDTH-1:0]          s_araddr,
    input  logic                           s_arvalid,
    output logic                           s_arready,
    output logic [DATA_WIDTH-1:0]          s_rdata,
    output logic [1:0]                     s_rresp,
    output logic                           s_rvalid,
    input  logic                           s_rready,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_flat
);

    localparam int NB = DATA_WIDTH / 8;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs;

    logic                  aw_held;
    logic [ADDR_WIDTH-1:0] aw_addr_q;
    logic                  w_held;
    logic [DATA_WIDTH-1:0] w_data_q;
    logic [NB-1:0]         w_strb_q;

    logic                  aw_hs, w_hs, ar_hs;
    logic                  addr_avail, data_avail, commit;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [DATA_WIDTH-1:0] cur_data;
    logic [NB-1:0]         cur_strb;
    logic                  wr_ok, rd_ok;
    logic [DATA_WIDTH-1:0] rd_val;

    // Readies depend only on local state so they never combinationally follow a valid.
    assign s_awready = !aw_held;
    assign s_wready  = !w_held;
    assign s_arready = !s_rvalid || s_rready;

    assign aw_hs = s_awvalid && s_awready;
    assign w_hs  = s_wvalid && s_wready;
    assign ar_hs = s_arvalid && s_arready;

    assign addr_avail = aw_held || aw_hs;
    assign data_avail = w_held || w_hs;
    assign commit     = addr_avail && data_avail && (!s_bvalid || s_bready);

    assign cur_addr = aw_held ? aw_addr_q : s_awaddr;
    assign cur_data = w_held  ? w_data_q  : s_wdata;
    assign cur_strb = w_held  ? w_strb_q  : s_wstrb;

    assign regs_flat = regs;

    // Out-of-range indices fall through the loop, leaving rd_val at zero.
    always_comb begin
        rd_val = '0;
        rd_ok  = 1'b0;
        wr_ok  = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (int'(s_araddr) == i) begin
                rd_val = regs[i];
                rd_ok  = 1'b1;
            end
            if (int'(cur_addr) == i) begin
                wr_ok = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_held   <= 1'b0;
            aw_addr_q <= '0;
            w_held    <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
        end else if (commit) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
        end else begin
            if (aw_hs) begin
                aw_held   <= 1'b1;
                aw_addr_q <= s_awaddr;
            end
            if (w_hs) begin
                w_held   <= 1'b1;
                w_data_q <= s_wdata;
                w_strb_q <= s_wstrb;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs <= '0;
        end else if (commit && wr_ok) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (int'(cur_addr) == i) begin
                    for (int j = 0; j < NB; j++) begin
                        if (cur_strb[j]) begin
                            regs[i][j*8 +: 8] <= cur_data[j*8 +: 8];
                        end
                    end
                end
            end
        end
    end

    // A new commit on the B handshake edge keeps bvalid high with the fresh response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_bvalid <= 1'b0;
            s_bresp  <= RESP_OKAY;
        end else if (commit) begin
            s_bvalid <= 1'b1;
            s_bresp  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
        end else if (s_bready) begin
            s_bvalid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_rvalid <= 1'b0;
            s_rdata  <= '0;
            s_rresp  <= RESP_OKAY;
        end else if (ar_hs) begin
            s_rvalid <= 1'b1;
            s_rdata  <= rd_val;
            s_rresp  <= rd_ok ? RESP_OKAY : RESP_SLVERR;
        end else if (s_rready) begin
            s_rvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_axi4lite_slave_regfile.sv
// Directed bench for axi4lite_slave_regfile: each task drives one scenario and checks inline.
module tb_axi4lite_slave_regfile;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  s_awaddr;
    logic        s_awvalid;
    logic        s_awready;
    logic [7:0]  s_wdata;
    logic [0:0]  s_wstrb;
    logic        s_wvalid;
    logic        s_wready;
    logic [1:0]  s_bresp;
    logic        s_bvalid;
    logic        s_bready;
    logic [1:0]  s_araddr;
    logic        s_arvalid;
    logic        s_arready;
    logic [7:0]  s_rdata;
    logic [1:0]  s_rresp;
    logic        s_rvalid;
    logic        s_rready;
    logic [23:0] regs_flat;

    int checks   = 0;
    int failures = 0;

    axi4lite_slave_regfile #(.ADDR_WIDTH(2), .DATA_WIDTH(8), .NUM_REGS(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .regs_flat(regs_flat)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        s_awaddr = '0; s_awvalid = 1'b0; s_wdata = '0; s_wstrb = '0; s_wvalid = 1'b0;
        s_bready = 1'b1; s_araddr = '0; s_arvalid = 1'b0; s_rready = 1'b1;
        tick(); tick();
        checks++;
        if ({s_awready, s_wready, s_arready} !== 3'b111) begin
            failures++; $display("FAIL reset_readies got=%b exp=111", {s_awready, s_wready, s_arready});
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if ({s_bvalid, s_rvalid, s_bresp, s_rresp, s_rdata, regs_flat} !== 38'd0) begin
            failures++;
            $display("FAIL reset_state got bv=%b rv=%b br=%b rr=%b rd=%h regs=%h exp all zero",
                     s_bvalid, s_rvalid, s_bresp, s_rresp, s_rdata, regs_flat);
        end
    endtask

    task automatic test_basic();
        s_awaddr = 2'd2; s_awvalid = 1'b1; s_wdata = 8'h04; s_wstrb = 1'b1; s_wvalid = 1'b1;
        tick();
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        checks++;
        if ({s_bvalid, s_bresp, regs_flat} !== {1'b1, 2'b00, 24'h04_00_00}) begin
            failures++; $display("FAIL basic_write got bv=%b br=%b regs=%h exp bv=1 br=00 regs=040000",
                                 s_bvalid, s_bresp, regs_flat);
        end
        s_araddr = 2'd2; s_arvalid = 1'b1;
        tick();
        s_arvalid = 1'b0;
        checks++;
        if ({s_rvalid, s_rdata, s_rresp, s_bvalid} !== {1'b1, 8'h04, 2'b00, 1'b0}) begin
            failures++; $display("FAIL basic_read got rv=%b rd=%h rr=%b bv=%b exp rv=1 rd=04 rr=00 bv=0",
                                 s_rvalid, s_rdata, s_rresp, s_bvalid);
        end
        tick();
        checks++;
        if (s_rvalid !== 1'b0) begin
            failures++; $display("FAIL basic_rvalid_clear got=%b exp=0", s_rvalid);
        end
    endtask

    task automatic test_w_first();
        s_wdata = 8'hA5; s_wstrb = 1'b1; s_wvalid = 1'b1;
        tick();
        s_wvalid = 1'b0;
        tick(); tick();
        checks++;
        if ({s_wready, s_awready, s_bvalid, regs_flat} !== {1'b0, 1'b1, 1'b0, 24'h04_00_00}) begin
            failures++; $display("FAIL w_held got wr=%b awr=%b bv=%b regs=%h exp wr=0 awr=1 bv=0 regs=040000",
                                 s_wready, s_awready, s_bvalid, regs_flat);
        end
        s_awaddr = 2'd1; s_awvalid = 1'b1;
        tick();
        s_awvalid = 1'b0;
        checks++;
        if ({s_bvalid, s_bresp, s_wready, regs_flat} !== {1'b1, 2'b00, 1'b1, 24'h04_A5_00}) begin
            failures++; $display("FAIL w_first_commit got bv=%b br=%b wr=%b regs=%h exp bv=1 br=00 wr=1 regs=04a500",
                                 s_bvalid, s_bresp, s_wready, regs_flat);
        end
        tick();
    endtask

    task automatic test_slverr();
        s_awaddr = 2'd3; s_awvalid = 1'b1; s_wdata = 8'hFF; s_wstrb = 1'b1; s_wvalid = 1'b1;
        tick();
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        checks++;
        if ({s_bvalid, s_bresp, regs_flat} !== {1'b1, 2'b10, 24'h04_A5_00}) begin
            failures++; $display("FAIL slverr_write got bv=%b br=%b regs=%h exp bv=1 br=10 regs=04a500",
                                 s_bvalid, s_bresp, regs_flat);
        end
        s_araddr = 2'd3; s_arvalid = 1'b1;
        tick();
        s_arvalid = 1'b0;
        checks++;
        if ({s_rvalid, s_rdata, s_rresp} !== {1'b1, 8'h00, 2'b10}) begin
            failures++; $display("FAIL slverr_read got rv=%b rd=%h rr=%b exp rv=1 rd=00 rr=10",
                                 s_rvalid, s_rdata, s_rresp);
        end
        tick();
    endtask

    task automatic test_b_stall();
        s_bready = 1'b0;
        s_awaddr = 2'd0; s_awvalid = 1'b1; s_wdata = 8'h11; s_wstrb = 1'b1; s_wvalid = 1'b1;
        tick();
        s_awaddr = 2'd1; s_wdata = 8'h33;
        tick();
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        tick();
        checks++;
        if ({s_awready, s_wready, s_bvalid, s_bresp, regs_flat} !== {1'b0, 1'b0, 1'b1, 2'b00, 24'h04_A5_11}) begin
            failures++; $display("FAIL b_stall_hold got awr=%b wr=%b bv=%b br=%b regs=%h exp awr=0 wr=0 bv=1 br=00 regs=04a511",
                                 s_awready, s_wready, s_bvalid, s_bresp, regs_flat);
        end
        s_bready = 1'b1;
        tick();
        checks++;
        if ({s_awready, s_wready, s_bvalid, regs_flat} !== {1'b1, 1'b1, 1'b1, 24'h04_33_11}) begin
            failures++; $display("FAIL b_stall_release got awr=%b wr=%b bv=%b regs=%h exp awr=1 wr=1 bv=1 regs=043311",
                                 s_awready, s_wready, s_bvalid, regs_flat);
        end
        tick();
        checks++;
        if (s_bvalid !== 1'b0) begin
            failures++; $display("FAIL b_stall_drain got bv=%b exp=0", s_bvalid);
        end
    endtask

    task automatic test_strb_zero();
        s_awaddr = 2'd2; s_awvalid = 1'b1; s_wdata = 8'hEE; s_wstrb = 1'b0; s_wvalid = 1'b1;
        tick();
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        checks++;
        if ({s_bvalid, s_bresp, regs_flat} !== {1'b1, 2'b00, 24'h04_33_11}) begin
            failures++; $display("FAIL strb_zero got bv=%b br=%b regs=%h exp bv=1 br=00 regs=043311",
                                 s_bvalid, s_bresp, regs_flat);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_data [3];
        exp_data[0] = 8'h11; exp_data[1] = 8'h33; exp_data[2] = 8'h04;
        s_arvalid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            s_araddr = 2'(i);
            tick();
            checks++;
            if ({s_rvalid, s_rdata, s_rresp} !== {1'b1, exp_data[i], 2'b00}) begin
                failures++; $display("FAIL b2b_read%0d got rv=%b rd=%h rr=%b exp rv=1 rd=%h rr=00",
                                     i, s_rvalid, s_rdata, s_rresp, exp_data[i]);
            end
        end
        s_arvalid = 1'b0;
        tick();
        checks++;
        if (s_rvalid !== 1'b0) begin
            failures++; $display("FAIL b2b_end got rv=%b exp=0", s_rvalid);
        end
    endtask

    task automatic test_r_stall();
        s_rready = 1'b0;
        s_araddr = 2'd1; s_arvalid = 1'b1;
        tick();
        s_araddr = 2'd2;
        tick();
        checks++;
        if ({s_rvalid, s_arready, s_rdata} !== {1'b1, 1'b0, 8'h33}) begin
            failures++; $display("FAIL r_stall_hold got rv=%b arr=%b rd=%h exp rv=1 arr=0 rd=33",
                                 s_rvalid, s_arready, s_rdata);
        end
        s_rready = 1'b1;
        tick();
        s_arvalid = 1'b0;
        checks++;
        if ({s_rvalid, s_rdata} !== {1'b1, 8'h04}) begin
            failures++; $display("FAIL r_stall_next got rv=%b rd=%h exp rv=1 rd=04", s_rvalid, s_rdata);
        end
        tick();
    endtask

    task automatic test_raw();
        s_awaddr = 2'd0; s_awvalid = 1'b1; s_wdata = 8'h77; s_wstrb = 1'b1; s_wvalid = 1'b1;
        s_araddr = 2'd0; s_arvalid = 1'b1;
        tick();
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        checks++;
        if ({s_rvalid, s_rdata, s_bvalid, regs_flat} !== {1'b1, 8'h11, 1'b1, 24'h04_33_77}) begin
            failures++; $display("FAIL raw_same_edge got rv=%b rd=%h bv=%b regs=%h exp rv=1 rd=11 bv=1 regs=043377",
                                 s_rvalid, s_rdata, s_bvalid, regs_flat);
        end
        tick();
        s_arvalid = 1'b0;
        checks++;
        if ({s_rvalid, s_rdata} !== {1'b1, 8'h77}) begin
            failures++; $display("FAIL raw_next_read got rv=%b rd=%h exp rv=1 rd=77", s_rvalid, s_rdata);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        s_wdata = 8'h5A; s_wstrb = 1'b1; s_wvalid = 1'b1;
        tick();
        s_wvalid = 1'b0;
        checks++;
        if (s_wready !== 1'b0) begin
            failures++; $display("FAIL mid_reset_setup got wr=%b exp=0", s_wready);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({s_wready, s_awready, s_bvalid, s_rvalid, regs_flat} !== {1'b1, 1'b1, 1'b0, 1'b0, 24'h0}) begin
            failures++; $display("FAIL mid_reset_async got wr=%b awr=%b bv=%b rv=%b regs=%h exp wr=1 awr=1 bv=0 rv=0 regs=000000",
                                 s_wready, s_awready, s_bvalid, s_rvalid, regs_flat);
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_w_first();
        test_slverr();
        test_b_stall();
        test_strb_zero();
        test_back_to_back();
        test_r_stall();
        test_raw();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
